id_ex_pipe: RTL and testbench

ID/EX pipeline register for the pipelined RV32 core, sitting directly downstream of the instruction decoder. It captures the decoder's control bundle together with the ID-stage operands and register indices, and presents them to EX one cycle later. It contains the load-use hazard detector, which stalls IF/ID and injects a bubble into EX, and it squashes the ID instruction on a taken branch or jump. A saturating counter records inserted bubbles for performance analysis.

---
 rtl/id_ex_pipe.sv | 109 ++++++++++
 tb/tb_id_ex_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, branch squash
// and a saturating count of inserted load-use bubbles.
module id_ex_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_RegWrite,
  input  logic             id_MemWrite,
  input  logic             id_MemRead,
  input  logic             id_ALUSrc,
  input  logic [4:0]       id_ALUOp,
  input  logic [4:0]       id_NPCOp,
  input  logic [1:0]       id_WDSel,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_MemRead,
  output logic             ex_ALUSrc,
  output logic [4:0]       ex_ALUOp,
  output logic [4:0]       ex_NPCOp,
  output logic [1:0]       ex_WDSel,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic lu;

  // Load in EX whose destination is a register the ID instruction really reads.
  always_comb begin
    lu = ex_valid & ex_MemRead & id_valid & (ex_rd != 5'd0) &
         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // A flush discards the ID instruction, so there is nothing left to stall for.
    stall = (lu | hold) & ~flush;
  end

  // Pipeline register: reset > flush > hold > load-use bubble > load.
  // Bubbles clear only valid/control; data fields keep their old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_NPCOp    <= '0;
      ex_WDSel    <= '0;
      bubble_cnt  <= '0;
    end else if (flush || (!hold && lu)) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_NPCOp    <= '0;
      ex_WDSel    <= '0;
      // Only genuine load-use bubbles are counted, never flushes.
      if (!flush && bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + 1'b1;
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      // Empty slots carry inert control; writes to x0 are dropped here.
      ex_RegWrite <= id_valid & id_RegWrite & (id_rd != 5'd0);
      ex_MemWrite <= id_valid & id_MemWrite;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_ALUSrc   <= id_valid & id_ALUSrc;
      ex_ALUOp    <= id_valid ? id_ALUOp : 5'd0;
      ex_NPCOp    <= id_valid ? id_NPCOp : 5'd0;
      ex_WDSel    <= id_valid ? id_WDSel : 2'd0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomized + directed bench for id_ex_pipe against a behavioural model.
module tb_id_ex_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;  // small so saturation is reachable
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit          valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    bit          use1, use2, rw, mw, mr, as;
    logic [4:0]  aluop, npcop;
    logic [1:0]  wdsel;
  } slot_t;

  logic clk = 1'b0;
  logic rst, flush, hold;
  slot_t ii;  // ID inputs
  slot_t m;   // model of the EX slot
  int    mcnt;

  logic             ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, stall;
  logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd, ex_ALUOp, ex_NPCOp;
  logic [1:0]       ex_WDSel;
  logic [CNT_W-1:0] bubble_cnt;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .id_valid(ii.valid), .id_pc(ii.pc), .id_rd1(ii.rd1), .id_rd2(ii.rd2), .id_imm(ii.imm),
    .id_rs1(ii.rs1), .id_rs2(ii.rs2), .id_rd(ii.rd),
    .id_use_rs1(ii.use1), .id_use_rs2(ii.use2),
    .id_RegWrite(ii.rw), .id_MemWrite(ii.mw), .id_MemRead(ii.mr), .id_ALUSrc(ii.as),
    .id_ALUOp(ii.aluop), .id_NPCOp(ii.npcop), .id_WDSel(ii.wdsel),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Is the ID instruction consuming the value a load in EX has not produced yet?
  function automatic bit hazard();
    bit reads = (ii.use1 && ii.rs1 == m.rd) || (ii.use2 && ii.rs2 == m.rd);
    return m.valid && m.mr && ii.valid && m.rd != 0 && reads;
  endfunction

  function automatic slot_t bubble(input slot_t s);
    slot_t b = s;
    b.valid = 0; b.rw = 0; b.mw = 0; b.mr = 0; b.as = 0;
    b.aluop = 0; b.npcop = 0; b.wdsel = 0;
    return b;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m = '{default: '0};
      mcnt = 0;
    end else if (flush) begin
      m = bubble(m);
    end else if (hold) begin
      // frozen
    end else if (hazard()) begin
      m = bubble(m);
      if (mcnt < CMAX) mcnt++;
    end else begin
      m = ii;
      if (!ii.valid) m = bubble(ii);
      m.valid = ii.valid;
      m.rw = m.rw && (ii.rd != 0);
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rd1", ex_rd1, m.rd1);
    chk("ex_rd2", ex_rd2, m.rd2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
    chk("ex_RegWrite", ex_RegWrite, m.rw);
    chk("ex_mem", {ex_MemWrite, ex_MemRead}, {m.mw, m.mr});
    chk("ex_ctrl", {ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_WDSel},
        {m.as, m.aluop, m.npcop, m.wdsel});
    chk("bubble_cnt", bubble_cnt, mcnt);
  endtask

  // Inputs are already driven; check stall mid-cycle, clock, then check EX.
  task automatic step(input bit chk_stall = 1);
    #1;
    if (chk_stall) chk("stall", stall, (hazard() || hold) && !flush);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    #1;
  endtask

  task automatic rand_instr();
    ii.valid = ($urandom_range(7) != 0);
    ii.pc    = $urandom; ii.rd1 = $urandom; ii.rd2 = $urandom; ii.imm = $urandom;
    ii.rs1   = 5'($urandom_range(3)); ii.rs2 = 5'($urandom_range(3)); ii.rd = 5'($urandom_range(3));
    ii.use1  = 1'($urandom); ii.use2 = 1'($urandom);
    ii.rw    = 1'($urandom); ii.mw = 1'($urandom); ii.as = 1'($urandom);
    ii.mr    = ($urandom_range(2) == 0);
    ii.aluop = 5'($urandom); ii.npcop = 5'($urandom); ii.wdsel = 2'($urandom);
  endtask

  task automatic instr(input logic [4:0] rd, rs1, rs2, input bit u1, u2, rw, mr);
    rand_instr();
    ii.valid = 1; ii.rd = rd; ii.rs1 = rs1; ii.rs2 = rs2;
    ii.use1 = u1; ii.use2 = u2; ii.rw = rw; ii.mr = mr; ii.mw = 0;
  endtask

  initial begin
    rst = 1; flush = 0; hold = 0;
    m = '{default: '0}; mcnt = 0;
    rand_instr();
    #2;
    // reset, two cycles with random ID inputs
    step(0);
    rand_instr();
    step(1);
    chk("reset_stall", stall, 1'b0);
    rst = 0;

    // pass-through: add x5,x6,x7
    instr(5, 6, 7, 1, 1, 1, 0);
    ii.pc = 32'h100; ii.aluop = 5'b00011;
    step();
    chk("pass_pc", ex_pc, 32'h100);
    chk("pass_rd", ex_rd, 5);
    chk("pass_aluop", ex_ALUOp, 5'b00011);

    // load-use: lw x5, then add x6,x5,x1 (one bubble, then advances)
    instr(5, 1, 0, 1, 0, 1, 1); step();
    instr(6, 5, 1, 1, 1, 1, 0); step();
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_cnt", bubble_cnt, 1);
    step();
    chk("lu_advance_rd", ex_rd, 6);
    chk("lu_advance_valid", ex_valid, 1'b1);

    // false hazards: lw x0; lui x5 after lw x5
    instr(0, 1, 0, 1, 0, 1, 1); step();
    instr(6, 0, 0, 1, 1, 1, 0); step();
    instr(5, 1, 0, 1, 0, 1, 1); step();
    instr(5, 5, 5, 0, 0, 1, 0); step();
    chk("false_cnt", bubble_cnt, 1);

    // flush beats lu and hold
    instr(5, 1, 0, 1, 0, 1, 1); step();
    instr(6, 5, 1, 1, 0, 1, 0); flush = 1; hold = 1; step();
    chk("flush_valid", ex_valid, 1'b0);
    flush = 0; hold = 0;

    // hold with lu: stall high, no count until hold drops
    instr(5, 1, 0, 1, 0, 1, 1); step();
    instr(6, 0, 5, 0, 1, 1, 0); hold = 1; step(); step();
    hold = 0; step(); step();

    // x0 guard
    instr(0, 1, 2, 1, 1, 1, 0); step();
    chk("x0_regwrite", ex_RegWrite, 1'b0);

    // saturation
    for (int k = 0; k < CMAX + 4; k++) begin
      instr(7, 1, 0, 1, 0, 1, 1); step();
      instr(8, 7, 0, 1, 0, 1, 0); step(); step();
    end
    chk("sat_cnt", bubble_cnt, CMAX);

    // reset mid-stream with everything else asserted
    instr(5, 1, 0, 1, 0, 1, 1); step();
    instr(6, 5, 0, 1, 0, 1, 0); rst = 1; flush = 1; hold = 1; step();
    chk("midrst_cnt", bubble_cnt, 0);
    rst = 0; flush = 0; hold = 0;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rand_instr();
      flush = ($urandom_range(9) == 0);
      hold  = ($urandom_range(5) == 0);
      rst   = ($urandom_range(99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
